// File: rtl/b1_cmd_rx.sv
// Receiver for the 30-byte "&B1," NCO command frame from the UART FIFO.
// Parsed fields land in shadow registers and are copied to the cmd_* outputs only on a good frame.
module b1_cmd_rx #(
    parameter int unsigned TIMEOUT_CYC = 77000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [31:0] cmd_boc_car_nco,
    output logic [31:0] cmd_tmboc_car_nco,
    output logic [31:0] cmd_boc_prn_nco,
    output logic [31:0] cmd_tmboc_prn_nco,
    output logic [11:0] cmd_boc_prn_phs,
    output logic [11:0] cmd_tmboc_prn_phs,
    output logic        cmd_load,
    output logic        cmd_err,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  err_cnt
);
    // state | meaning
    // IDLE  | hunting for '&'; other bytes dropped silently
    // HDR   | checking "B1," (index 1-3)
    // BODY  | fields and inner commas (index 4-26)
    // TRAIL | checking "#\r\n" (index 27-29)
    typedef enum logic [1:0] {IDLE, HDR, BODY, TRAIL} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   sh_bcar_q, sh_bcar_d, sh_tcar_q, sh_tcar_d;
    logic [31:0]   sh_bprn_q, sh_bprn_d, sh_tprn_q, sh_tprn_d;
    logic [11:0]   sh_bphs_q, sh_bphs_d, sh_tphs_q, sh_tphs_d;
    logic [31:0]   o_bcar_q, o_bcar_d, o_tcar_q, o_tcar_d;
    logic [31:0]   o_bprn_q, o_bprn_d, o_tprn_q, o_tprn_d;
    logic [11:0]   o_bphs_q, o_bphs_d, o_tphs_q, o_tphs_d;
    logic          load_q, load_d, err_q, err_d;
    logic [7:0]    fcnt_q, fcnt_d, ecnt_q, ecnt_d;
    logic [7:0]    exp_byte;
    logic          bad, done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            sh_bcar_q <= '0;
            sh_tcar_q <= '0;
            sh_bprn_q <= '0;
            sh_tprn_q <= '0;
            sh_bphs_q <= '0;
            sh_tphs_q <= '0;
            o_bcar_q  <= '0;
            o_tcar_q  <= '0;
            o_bprn_q  <= '0;
            o_tprn_q  <= '0;
            o_bphs_q  <= '0;
            o_tphs_q  <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            sh_bcar_q <= sh_bcar_d;
            sh_tcar_q <= sh_tcar_d;
            sh_bprn_q <= sh_bprn_d;
            sh_tprn_q <= sh_tprn_d;
            sh_bphs_q <= sh_bphs_d;
            sh_tphs_q <= sh_tphs_d;
            o_bcar_q  <= o_bcar_d;
            o_tcar_q  <= o_tcar_d;
            o_bprn_q  <= o_bprn_d;
            o_tprn_q  <= o_tprn_d;
            o_bphs_q  <= o_bphs_d;
            o_tphs_q  <= o_tphs_d;
            load_q    <= load_d;
            err_q     <= err_d;
            fcnt_q    <= fcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        sh_bcar_d = sh_bcar_q;
        sh_tcar_d = sh_tcar_q;
        sh_bprn_d = sh_bprn_q;
        sh_tprn_d = sh_tprn_q;
        sh_bphs_d = sh_bphs_q;
        sh_tphs_d = sh_tphs_q;
        o_bcar_d  = o_bcar_q;
        o_tcar_d  = o_tcar_q;
        o_bprn_d  = o_bprn_q;
        o_tprn_d  = o_tprn_q;
        o_bphs_d  = o_bphs_q;
        o_tphs_d  = o_tphs_q;
        load_d    = 1'b0;
        err_d     = 1'b0;
        fcnt_d    = fcnt_q;
        ecnt_d    = ecnt_q;
        bad       = 1'b0;
        done      = 1'b0;
        exp_byte  = 8'h2C;
        case (idx_q)
            5'd1:    exp_byte = 8'h42;
            5'd2:    exp_byte = 8'h31;
            5'd27:   exp_byte = 8'h23;
            5'd28:   exp_byte = 8'h0D;
            5'd29:   exp_byte = 8'h0A;
            default: exp_byte = 8'h2C;
        endcase

        if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_byte == 8'h26) begin
                        state_d = HDR;
                        idx_d   = 5'd1;
                    end
                end
                HDR: begin
                    bad = (rx_byte != exp_byte);
                    if (!bad) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd3) state_d = BODY;
                    end
                end
                BODY: begin
                    // Field positions take any byte value; only indices 8/13/20 are delimiters.
                    case (idx_q)
                        5'd8, 5'd13, 5'd20:       bad = (rx_byte != exp_byte);
                        5'd4, 5'd5, 5'd6, 5'd7:   sh_bcar_d = {sh_bcar_q[23:0], rx_byte};
                        5'd9, 5'd10, 5'd11, 5'd12: sh_tcar_d = {sh_tcar_q[23:0], rx_byte};
                        5'd14: begin
                            bad       = (rx_byte[7:4] != 4'h0);
                            sh_bphs_d = {rx_byte[3:0], sh_bphs_q[7:0]};
                        end
                        5'd15:                    sh_bphs_d = {sh_bphs_q[11:8], rx_byte};
                        5'd16, 5'd17, 5'd18, 5'd19: sh_bprn_d = {sh_bprn_q[23:0], rx_byte};
                        5'd21: begin
                            bad       = (rx_byte[7:4] != 4'h0);
                            sh_tphs_d = {rx_byte[3:0], sh_tphs_q[7:0]};
                        end
                        5'd22:                    sh_tphs_d = {sh_tphs_q[11:8], rx_byte};
                        default:                  sh_tprn_d = {sh_tprn_q[23:0], rx_byte};
                    endcase
                    if (!bad) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd26) state_d = TRAIL;
                    end
                end
                TRAIL: begin
                    bad = (rx_byte != exp_byte);
                    if (!bad) begin
                        if (idx_q == 5'd29) done = 1'b1;
                        else idx_d = idx_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (bad) begin
                err_d  = 1'b1;
                ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
                // A stray '&' is most likely the start of the next frame.
                if (rx_byte == 8'h26) begin
                    state_d = HDR;
                    idx_d   = 5'd1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end

            if (done) begin
                load_d   = 1'b1;
                fcnt_d   = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
                o_bcar_d = sh_bcar_q;
                o_tcar_d = sh_tcar_q;
                o_bprn_d = sh_bprn_q;
                o_tprn_d = sh_tprn_q;
                o_bphs_d = sh_bphs_q;
                o_tphs_d = sh_tphs_q;
                state_d  = IDLE;
                idx_d    = '0;
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                ecnt_d  = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
                state_d = IDLE;
                idx_d   = '0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign cmd_boc_car_nco   = o_bcar_q;
    assign cmd_tmboc_car_nco = o_tcar_q;
    assign cmd_boc_prn_nco   = o_bprn_q;
    assign cmd_tmboc_prn_nco = o_tprn_q;
    assign cmd_boc_prn_phs   = o_bphs_q;
    assign cmd_tmboc_prn_phs = o_tphs_q;
    assign cmd_load          = load_q;
    assign cmd_err           = err_q;
    assign frame_cnt         = fcnt_q;
    assign err_cnt           = ecnt_q;
endmodule

// File: doc/b1_cmd_rx.md
B1_CMD_RX -- requirements
Module: b1_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 77000, meaning the inter-byte timeout in clk cycles (1 ms at 77 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port rx_byte  input  8  received byte from the UART receive FIFO.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_byte is valid while it is high.
REQ-006 SHALL have ports cmd_boc_car_nco, cmd_tmboc_car_nco, cmd_boc_prn_nco and cmd_tmboc_prn_nco  output  32 each  commanded carrier and PRN NCO words (data and pilot channels).
REQ-007 SHALL have ports cmd_boc_prn_phs and cmd_tmboc_prn_phs  output  12 each  commanded PRN phase (data and pilot channels).
REQ-008 SHALL have port cmd_load  output  1  one-cycle strobe: new command words are valid.
REQ-009 SHALL have port cmd_err  output  1  one-cycle strobe: frame rejected.
REQ-010 SHALL have ports frame_cnt and err_cnt  output  8 each  counts of good and rejected frames.

Function
REQ-011 SHALL parse a 30-byte frame. Byte index i has this meaning:
- i 0-3: '&' 'B' '1' ','
- i 4-7: boc_car_nco, MSB first
- i 8: ','
- i 9-12: tmboc_car_nco
- i 13: ','
- i 14-15: boc_prn_phs, high byte then low byte
- i 16-19: boc_prn_nco
- i 20: ','
- i 21-22: tmboc_prn_phs
- i 23-26: tmboc_prn_nco
- i 27-29: '#' 0x0D 0x0A
REQ-012 SHALL use the FSM states IDLE, HDR, BODY and TRAIL, and SHALL act only on cycles where rx_valid=1.
REQ-013 IDLE: rx_byte 0x26 -> HDR with index 1; any other byte is discarded silently, with no cmd_err.
REQ-014 HDR: checks i 1-3 against 'B','1',','; after i=3 -> BODY.
REQ-015 BODY: checks delimiter bytes at i 8, 13 and 20, and shifts field bytes into shadow registers; after i=26 -> TRAIL.
REQ-016 BODY: a phase high byte (i 14 or 21) SHALL have bits[7:4]=0; bits[3:0] map to phs[11:8].
REQ-017 TRAIL: checks i 27-29; a match at i=29 completes the frame and returns the FSM to IDLE.
REQ-018 On frame completion, SHALL copy the shadow registers to the cmd_* outputs, pulse cmd_load and increment frame_cnt, all on the clock edge after the accepting LF byte edge (registered, 1-cycle latency).
REQ-019 cmd_* outputs SHALL change only on cmd_load; a rejected frame SHALL leave them unchanged.
REQ-020 Any mismatch outside IDLE SHALL pulse cmd_err (one cycle after the offending byte) and increment err_cnt.
REQ-021 On a mismatch, the next state SHALL be:
- HDR with index 1 if the offending byte is 0x26 (resynchronisation);
- IDLE otherwise.
REQ-022 Outside IDLE, a silence of TIMEOUT_CYC consecutive cycles without rx_valid SHALL pulse cmd_err, increment err_cnt and return the FSM to IDLE.
REQ-023 The timeout counter SHALL clear on every rx_valid and SHALL be held at 0 in IDLE.
REQ-024 Field bytes (i 4-7, 9-12, 14-19, 21-26) SHALL be accepted with any value, including 0x26, 0x2C, 0x23, 0x0D and 0x0A; these bytes are never treated as delimiters.
REQ-025 frame_cnt and err_cnt SHALL saturate at 255.
REQ-026 cmd_load and cmd_err SHALL never be asserted in the same cycle.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force:
- FSM to IDLE;
- index, timeout counter and shadow registers to 0;
- all cmd_* outputs, cmd_load, cmd_err, frame_cnt and err_cnt to 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame with no cmd_err or cmd_load pulse; after release, parsing SHALL resume only at the next 0x26.

Verification
REQ-029 Valid frame (car 0x12345678/0x9ABCDEF0, phs 0x3FF/0x001, prn 0x0A0B0C0D/0x11223344) -> one cmd_load 1 cycle after LF, outputs equal these values, frame_cnt=1.
REQ-030 Same frame with i=8 = 0x2E -> cmd_err 1 cycle later, outputs unchanged, err_cnt=1, next valid frame loads.
REQ-031 Frame truncated after i=15, idle 77000 cycles -> exactly one cmd_err at the timeout, FSM in IDLE; the next full frame loads.
REQ-032 Garbage bytes 0x00 0x41 0x0D before a valid frame -> no cmd_err, one cmd_load.
REQ-033 Header "&B&B1,..." -> cmd_err at the second '&', resync, and the following frame loads correctly.
REQ-034 rst_n low for 1 cycle at i=20, then a valid frame -> no cmd_err, cmd_load once, counters 1/0.
